sound_scheduler: RTL
====================

# sound_scheduler

Sequencer and arbiter for the game's sound datapath. It accepts sound requests from gameplay events (good collision, bad collision, button press, direction change), queues them, and arbitrates them by fixed priority. It plays each request as a short timed note sequence by driving the frequency code, play enable and ON/OFF mode into the oscillator/DAC chain. It sits between the event sources and the oscillator, replacing free-running per-event playback with timed, non-overlapping jingles.

## Interface
- NOTE_CYCLES, default 1_000_000: clock cycles each note is sounded; must be ≥1.
- GAP_CYCLES, default 250_000: silent cycles after each note; 0 means no gap state is entered.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- goodColl_i  in  1  good-collision level, synchronous to clk.
- badColl_i  in  1  bad-collision level, synchronous.
- button_i  in  1  button level, synchronous.
- direction_i  in  4  direction levels; bit0 up, bit1 down, bit2 left, bit3 right.
- freq_o  out  9  frequency code to the oscillator.
- playSound_o  out  1  oscillator enable; high only while a note sounds.
- mode_o  out  MODE_TYPES  ON while a sequence is active, else OFF.
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
- Request capture:
  - Each source has an edge register (reset 0) and a pending bit.
  - A rising edge (current 1, registered 0) sets the pending bit.
  - Direction has one pending bit plus a 4-bit latched vector; a new edge on any bit ORs into the vector.
  - A re-request while a bit is already pending merges; no count is kept.
  - An input held high through reset release registers a request at the first clock edge.
- Priority, highest first: badColl, goodColl, button, direction. Within direction, the lowest set bit wins.
- Sequences (freq codes):
  - badColl: 100 then 80.
  - goodColl: 300 then 400.
  - button: 250.
  - direction: up 200, down 150, left 175, right 225.
- FSM states: IDLE, NOTE, GAP.
  - IDLE → NOTE when any bit is pending. The winner's pending bit (and direction vector) is cleared. Note index is set to 0 and the counter to 0.
  - NOTE → GAP when counter = NOTE_CYCLES−1. If GAP_CYCLES = 0, NOTE goes directly to the next-step decision.
  - GAP → next step when counter = GAP_CYCLES−1:
    - more notes in the sequence: NOTE with index+1;
    - else, anything pending: NOTE for the new winner;
    - else: IDLE.
- Preemption: a pending badColl while in NOTE/GAP of any other source causes the next edge to enter NOTE with badColl note 0. The preempted sequence is dropped and not resumed. badColl never preempts badColl; that request stays pending.
- Set vs clear conflict: if a new edge arrives in the same cycle its pending bit is cleared for service, set wins and the request is re-queued.
- Outputs:
  - playSound_o = 1 only in NOTE.
  - freq_o holds the current note's code in NOTE and GAP. It keeps its last value in IDLE.
  - mode_o = ON and busy_o = 1 in NOTE and GAP.
- Counter width is $clog2(max(NOTE_CYCLES, GAP_CYCLES)+1). The counter resets to 0 on every state or note change.

## Timing
- Reset values (asynchronous, immediate on rst): state IDLE, freq_o 0, playSound_o 0, mode_o OFF, busy_o 0, all pending/edge/vector registers 0, counter 0.
- Latency: input rises before edge E0, pending sets at E0, NOTE is entered at E1. playSound_o is high from E1 for exactly NOTE_CYCLES cycles.
- Back-to-back service: the next NOTE starts on the edge that ends the previous GAP, with no IDLE cycle.
- Reset mid-sequence aborts playback immediately and discards all pending requests.

## Structure
- Shared package sound_pkg holds:
  - MODE_TYPES (OFF = 0, ON = 1);
  - the FSM state enum;
  - the source enum;
  - all nine-bit freq constants.
- One sub-module, sound_req_latch, holds the edge detect and pending bit for one source, with set/clear inputs and set-wins priority. Instantiate it four times. The direction vector stays in the top.

## Test plan
Run with NOTE_CYCLES=4, GAP_CYCLES=2.
- Reset: assert rst mid-note → all outputs 0/OFF in the same cycle; after release, busy_o stays 0 with inputs low.
- button_i rises before E0 → playSound_o=1 with freq_o=250 for E1–E4, 0 for E5–E6; busy_o falls at E7.
- goodColl_i pulse → 300 for 4 cycles, gap 2, 400 for 4 cycles, gap 2, then IDLE; 12 busy cycles total.
- button_i and direction_i=4'b0110 rise together → button 250 sequence, then immediately down at 150; left is discarded when the vector clears.
- button note playing, badColl_i rises at its 2nd note cycle → freq_o=100 from the following edge, counter restarts, button not resumed.
- goodColl_i re-pulsed three times while goodColl is pending → exactly one goodColl sequence is played.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and note tables for the sound scheduler.
package sound_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } MODE_TYPES;

  typedef enum logic [1:0] {
    StIdle,
    StNote,
    StGap
  } state_e;

  // Enumerator order is also the arbitration order, highest priority first.
  typedef enum logic [1:0] {
    SrcBad    = 2'd0,
    SrcGood   = 2'd1,
    SrcButton = 2'd2,
    SrcDir    = 2'd3
  } src_e;

  localparam logic [8:0] FreqBad0   = 9'd100;
  localparam logic [8:0] FreqBad1   = 9'd80;
  localparam logic [8:0] FreqGood0  = 9'd300;
  localparam logic [8:0] FreqGood1  = 9'd400;
  localparam logic [8:0] FreqButton = 9'd250;
  localparam logic [8:0] FreqUp     = 9'd200;
  localparam logic [8:0] FreqDown   = 9'd150;
  localparam logic [8:0] FreqLeft   = 9'd175;
  localparam logic [8:0] FreqRight  = 9'd225;

  // Collision jingles have two notes; everything else has one.
  function automatic logic is_last_note(input src_e src, input logic idx);
    logic last;
    last = 1'b1;
    if (src == SrcBad || src == SrcGood) last = idx;
    return last;
  endfunction

  // Frequency code of note idx for a source; dir selects the direction tone.
  function automatic logic [8:0] note_freq(input src_e src, input logic [1:0] dir,
                                           input logic idx);
    logic [8:0] f;
    f = FreqButton;
    unique case (src)
      SrcBad:    f = idx ? FreqBad1 : FreqBad0;
      SrcGood:   f = idx ? FreqGood1 : FreqGood0;
      SrcButton: f = FreqButton;
      SrcDir: begin
        unique case (dir)
          2'd0: f = FreqUp;
          2'd1: f = FreqDown;
          2'd2: f = FreqLeft;
          2'd3: f = FreqRight;
          default: f = FreqUp;
        endcase
      end
      default: f = FreqButton;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sound_req_latch.sv
// Edge detector plus pending bit for one request source. A new rising edge
// beats a same-cycle clear so a request arriving during service is re-queued.
module sound_req_latch #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] level_i,
  input  logic             clear_i,
  output logic [Width-1:0] rise_o,
  output logic             pending_o
);

  logic [Width-1:0] level_q;
  logic             pending_q, pending_d;

  assign rise_o    = level_i & ~level_q;
  assign pending_o = pending_q;

  // Set-wins update of the pending bit.
  always_comb begin
    pending_d = pending_q;
    if (|rise_o) begin
      pending_d = 1'b1;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  // Edge history and pending state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      level_q   <= level_i;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Queues gameplay sound requests, arbitrates by fixed priority and plays each
// as a timed note sequence into the oscillator.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int unsigned NOTE_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES  = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic       button_i,
  input  logic [3:0] direction_i,
  output logic [8:0] freq_o,
  output logic       playSound_o,
  output MODE_TYPES  mode_o,
  output logic       busy_o
);

  localparam int unsigned MaxCycles = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] NoteLast = CntW'(NOTE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = (GAP_CYCLES == 0) ? '0 : CntW'(GAP_CYCLES - 1);

  logic [3:0] pend;
  logic [3:0] clr;
  logic [3:0] dir_rise;
  logic [2:0] unused_rise;

  state_e          state_q, state_d;
  src_e            src_q, src_d;
  logic            idx_q, idx_d;
  logic [1:0]      dir_sel_q, dir_sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      freq_q, freq_d;
  logic [3:0]      dir_vec_q, dir_vec_d;

  src_e       win_src;
  logic [1:0] dir_first;
  logic       any_pend;
  logic       preempt;
  logic       launch;
  logic       step;

  sound_req_latch #(.Width(1)) u_bad (
    .clk       (clk),
    .rst       (rst),
    .level_i   (badColl_i),
    .clear_i   (clr[SrcBad]),
    .rise_o    (unused_rise[0]),
    .pending_o (pend[SrcBad])
  );

  sound_req_latch #(.Width(1)) u_good (
    .clk       (clk),
    .rst       (rst),
    .level_i   (goodColl_i),
    .clear_i   (clr[SrcGood]),
    .rise_o    (unused_rise[1]),
    .pending_o (pend[SrcGood])
  );

  sound_req_latch #(.Width(1)) u_button (
    .clk       (clk),
    .rst       (rst),
    .level_i   (button_i),
    .clear_i   (clr[SrcButton]),
    .rise_o    (unused_rise[2]),
    .pending_o (pend[SrcButton])
  );

  sound_req_latch #(.Width(4)) u_dir (
    .clk       (clk),
    .rst       (rst),
    .level_i   (direction_i),
    .clear_i   (clr[SrcDir]),
    .rise_o    (dir_rise),
    .pending_o (pend[SrcDir])
  );

  // Fixed-priority winner among pending sources.
  always_comb begin
    any_pend = |pend;
    win_src  = SrcDir;
    if (pend[SrcBad]) begin
      win_src = SrcBad;
    end else if (pend[SrcGood]) begin
      win_src = SrcGood;
    end else if (pend[SrcButton]) begin
      win_src = SrcButton;
    end
  end

  // Lowest set direction bit wins within the direction source.
  always_comb begin
    dir_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dir_vec_q[i]) dir_first = 2'(i);
    end
  end

  // Direction vector: service clears it, but fresh edges in the same cycle survive.
  always_comb begin
    dir_vec_d = (clr[SrcDir] ? 4'b0000 : dir_vec_q) | dir_rise;
  end

  assign preempt = pend[SrcBad] && (src_q != SrcBad);

  // Sequencer next-state: note timing, next-step decision and preemption.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    dir_sel_d = dir_sel_q;
    cnt_d     = cnt_q + CntW'(1);
    freq_d    = freq_q;
    clr       = 4'b0000;
    launch    = 1'b0;
    step      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (any_pend) launch = 1'b1;
      end
      StNote: begin
        if (preempt) begin
          launch = 1'b1;
        end else if (cnt_q == NoteLast) begin
          if (GAP_CYCLES == 0) begin
            step = 1'b1;
          end else begin
            state_d = StGap;
            cnt_d   = '0;
          end
        end
      end
      StGap: begin
        if (preempt) begin
          launch = 1'b1;
        end else if (cnt_q == GapLast) begin
          step = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (step) begin
      if (!is_last_note(src_q, idx_q)) begin
        state_d = StNote;
        idx_d   = 1'b1;
        cnt_d   = '0;
        freq_d  = note_freq(src_q, dir_sel_q, 1'b1);
      end else if (any_pend) begin
        launch = 1'b1;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end

    // Starting a sequence always begins at note 0 with a fresh count.
    if (launch) begin
      state_d      = StNote;
      src_d        = win_src;
      idx_d        = 1'b0;
      cnt_d        = '0;
      dir_sel_d    = dir_first;
      freq_d       = note_freq(win_src, dir_first, 1'b0);
      clr[win_src] = 1'b1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= SrcBad;
      idx_q     <= 1'b0;
      dir_sel_q <= 2'd0;
      cnt_q     <= '0;
      freq_q    <= '0;
      dir_vec_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      dir_sel_q <= dir_sel_d;
      cnt_q     <= cnt_d;
      freq_q    <= freq_d;
      dir_vec_q <= dir_vec_d;
    end
  end

  // Outputs decode straight from registers so reset clears them immediately.
  always_comb begin
    playSound_o = (state_q == StNote);
    busy_o      = (state_q != StIdle);
    mode_o      = busy_o ? ON : OFF;
    freq_o      = freq_q;
  end

endmodule
